// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, fetch FSM states and instruction field slices shared across the MIPS core
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J = 6'b000010;
  localparam int IMM16_MSB = 15;
  localparam int IMM16_LSB = 0;
  localparam int TARGET26_MSB = 25;
  localparam int TARGET26_LSB = 0;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} fetch_state_t;
endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: next-PC select; in pc_plus4/instr/branch/jump/alu_zero, out next_pc (jump > taken branch > pc+4)
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        branch,
  input  logic        jump,
  input  logic        alu_zero,
  output logic [31:0] next_pc
);
  logic [31:0] br_off;
  logic unused_opcode;
  assign unused_opcode = ^instr[31:26];
  assign br_off = {{14{instr[IMM16_MSB]}}, instr[IMM16_MSB:IMM16_LSB], 2'b00};
  assign next_pc = jump ? {pc_plus4[31:28], instr[TARGET26_MSB:TARGET26_LSB], 2'b00} :
                   (branch && alu_zero) ? pc_plus4 + br_off : pc_plus4;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: multi-cycle fetch; imem req/ready/addr/rdata in, IR out via instr valid/ready, branch/jump/alu_zero pick next pc, pc/pc_plus4/retired status
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  input  logic        instr_ready,
  input  logic        branch,
  input  logic        jump,
  input  logic        alu_zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retired
);
  fetch_state_t state, state_n;
  logic [31:0] next_pc;
  logic accept;
  assign pc_plus4 = pc + 32'd4;
  assign imem_addr = pc;
  assign accept = (state == HOLD) && instr_ready;
  next_pc_calc u_next_pc (
    .pc_plus4(pc_plus4),
    .instr(instr),
    .branch(branch),
    .jump(jump),
    .alu_zero(alu_zero),
    .next_pc(next_pc)
  );
  // req/valid decode from state only, so reset drops them asynchronously
  always_comb begin
    state_n = state;
    imem_req = state == FETCH;
    instr_valid = state == HOLD;
    state_n = state == IDLE ? FETCH :
              state == FETCH ? (imem_ready ? HOLD : FETCH) :
              (instr_ready ? FETCH : HOLD);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      instr <= '0;
      retired <= '0;
    end else begin
      state <= state_n;
      if (state == FETCH && imem_ready) instr <= imem_rdata;
      if (accept) begin
        pc <= next_pc;
        retired <= retired + 32'd1;
      end
    end
  end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Multi-cycle instruction fetch front end for the MIPS core. It is the other end of the decode interface. It holds the PC, fetches 32-bit words from instruction memory through a req/ready handshake, and presents each instruction (and its opcode field) to the control unit and datapath through a valid/ready handshake. The control unit's `Branch` and `Jump` decisions come back in, together with the ALU zero flag, and the block uses them to select the next PC.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Must be word aligned.

Ports:
- `clk`  in  1  system clock. All state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  byte address of the fetch. Equals `pc`.
- `imem_ready`  in  1  memory returns `imem_rdata` this cycle. Ignored unless `imem_req`=1.
- `imem_rdata`  in  32  instruction word.
- `instr_valid`  out  1  `instr` holds an unconsumed instruction.
- `instr`  out  32  instruction register (IR). `instr[31:26]` drives the control unit's opcode input.
- `instr_ready`  in  1  downstream consumes `instr` this cycle.
- `branch`  in  1  control unit `Branch`. Sampled only on the accept cycle.
- `jump`  in  1  control unit `Jump`. Sampled only on the accept cycle.
- `alu_zero`  in  1  ALU zero flag for the current instruction. Sampled only on the accept cycle.
- `pc`  out  32  address of the instruction currently in or being fetched into IR.
- `pc_plus4`  out  32  `pc`+4, used for link and debug.
- `retired`  out  32  count of accepted instructions. Wraps modulo 2^32.

## Operation
- FSM states:
  - IDLE: entered on reset. Goes to FETCH unconditionally on the next edge.
  - FETCH: `imem_req`=1, driven combinationally from state. On `imem_ready`=1, IR is loaded from `imem_rdata` and the FSM goes to HOLD. Otherwise it stays in FETCH with `imem_addr` stable.
  - HOLD: `instr_valid`=1. When `instr_ready`=1 (accept), the PC is updated, `retired` is incremented and the FSM returns to FETCH. Otherwise it stays in HOLD with `instr` stable.
- Next-PC selection on accept, in priority order:
  - `jump`=1: {`pc_plus4`[31:28], `instr`[25:0], 2'b00}.
  - `branch`=1 and `alu_zero`=1: `pc_plus4` + (sign-extended `instr`[15:0] << 2), modulo 2^32.
  - otherwise: `pc_plus4`.
- `branch`, `jump` and `alu_zero` are don't-care outside the accept cycle.
- `pc` bits [1:0] stay 00 by construction. There is no misalignment check.
- All arithmetic is 32-bit unsigned with wrap. `pc`=32'hFFFF_FFFC gives `pc_plus4`=0.
- Reset values: state IDLE, `pc`=RESET_PC, `instr`=0, `instr_valid`=0, `imem_req`=0, `retired`=0.
- Reset mid-operation: an outstanding fetch is abandoned and `imem_req` falls immediately (asynchronously). The memory must tolerate an abandoned request. A late `imem_ready` arriving in IDLE is ignored.
- `instr_ready` in any state other than HOLD is ignored.

## Timing
- Fetch request: the first `imem_req` appears 1 cycle after reset deasserts.
- Minimum per-instruction period is 2 cycles:
  - FETCH, with `imem_ready`=1 in the same cycle.
  - HOLD, with `instr_ready`=1 in the same cycle.
- Instruction visibility: `instr` and `instr_valid` appear on the edge after the `imem_ready` cycle.
- PC update: the new `pc` is visible on the edge after the accept cycle. The next fetch starts that same cycle.
- Handshake rules:
  - IMEM: `imem_addr` is held stable while `imem_req`=1 and `imem_ready`=0.
  - Decode: `instr` is held stable while `instr_valid`=1 and `instr_ready`=0.
- No combinational path from `imem_ready` or `instr_ready` to any output except through state.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants: OP_RTYPE 6'b000000, OP_LW 6'b100011, OP_SW 6'b101011, OP_BEQ 6'b000100, OP_J 6'b000010;
  - the fetch FSM state enum (IDLE, FETCH, HOLD);
  - the field-slice constants for imm16 and target26.
- One combinational sub-module, `next_pc_calc`:
  - inputs: `pc_plus4`, `instr`, `branch`, `jump`, `alu_zero`;
  - output: `next_pc`.
  It is reused later by a pipelined fetch stage.

## Test plan
- Reset with RESET_PC=32'h0040_0000, then release. Required:
  - 1 cycle later, `imem_req`=1 and `imem_addr`=32'h0040_0000;
  - `instr_valid`=0 throughout reset.
- Sequential fetch:
  - `imem_rdata`=32'h8C08_0004 (lw) with `imem_ready` immediate;
  - accept with `branch`=`jump`=0.
  - Required: next `imem_addr`=32'h0040_0004 and `retired`=1.
- beq at `pc`=32'h100, `instr`=32'h1000_FFFF, `branch`=1:
  - `alu_zero`=1: next `pc`=32'h100;
  - repeat with `alu_zero`=0: next `pc`=32'h104.
- j at `pc`=32'h0040_0008, `instr`=32'h0800_0040, `jump`=1 and `branch`=1 together. Required: next `pc`=32'h0000_0100 (jump wins).
- Stalls:
  - `imem_ready` held low 3 cycles: `imem_addr` is stable throughout, then IR is captured;
  - `instr_ready` held low 2 cycles: `instr` is stable and `retired` is unchanged.
- Assert `reset` while in FETCH with `imem_ready`=0. Required:
  - `imem_req` drops within the same cycle;
  - `pc`=RESET_PC, `retired`=0;
  - a late `imem_ready` pulse is ignored.
